sccb_master: RTL

- SCCB bus controller that is the responder end of the command interface used by the camera configuration sequencer.
- Accepts write and read commands (mcmd/maddr/mdata), executes them as SCCB 3-phase write or 2-phase-write + 2-phase-read cycles on SIO_C/SIO_D, and returns a completion response with read data.
- Sits between the config sequencer and the camera pads.

---
 rtl/sccb_pkg.sv | 32 +++
 rtl/sccb_tick_gen.sv | 33 +++
 rtl/sccb_master.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/sccb_pkg.sv
// Shared command/response codes, FSM encoding and bus timing constants for the
// SCCB master and its prescaler.
package sccb_pkg;

  localparam logic [2:0] MCMD_IDLE = 3'd0;
  localparam logic [2:0] MCMD_WR   = 3'd1;
  localparam logic [2:0] MCMD_RD   = 3'd2;

  localparam logic [1:0] SRESP_NULL = 2'd0;
  localparam logic [1:0] SRESP_DVA  = 2'd1;
  localparam logic [1:0] SRESP_ERR  = 2'd3;

  localparam int BIT_QUARTERS = 4;
  localparam int GAP_TICKS    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERR,
    ST_START,
    ST_BITS,
    ST_STOP,
    ST_GAP,
    ST_RESP,
    ST_HOLD
  } state_e;

  // First byte of every phase: 7-bit device ID followed by the R/W flag.
  function automatic logic [7:0] addr_byte(input logic [6:0] id, input logic rd);
    return {id, rd};
  endfunction

endpackage

// File: rtl/sccb_tick_gen.sv
// Quarter-bit tick prescaler: counts 0..max(sccb_div,1) and pulses tick on the
// terminal count; held at zero while disabled.
module sccb_tick_gen (
  input  logic       config_clk,
  input  logic       config_reset,
  input  logic       enable,
  input  logic [7:0] sccb_div,
  output logic       tick
);

  logic [7:0] count_q, count_d;
  logic [7:0] limit;

  always_comb begin
    limit = (sccb_div == 8'd0) ? 8'd1 : sccb_div;
    // >= so a divider lowered mid-count still wraps instead of running to 255
    tick  = enable && (count_q >= limit);
    if (!enable || tick) begin
      count_d = 8'd0;
    end else begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge config_clk) begin
    if (config_reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sccb_master.sv
// SCCB bus master: accepts write/read commands from the config sequencer and
// runs them as 3-phase write or 2-phase write + 2-phase read cycles.
module sccb_master
  import sccb_pkg::*;
(
  input  logic        config_clk,
  input  logic        config_reset,
  input  logic [7:0]  sccb_div,
  input  logic [2:0]  mcmd,
  input  logic [14:0] maddr,
  input  logic [7:0]  mdata,
  output logic        scmdaccept,
  output logic [1:0]  sresp,
  output logic [7:0]  sdata,
  output logic        sio_c,
  output logic        sio_d_out,
  output logic        sio_d_oe,
  input  logic        sio_d_in
);

  localparam logic [1:0] LAST_Q   = 2'(BIT_QUARTERS - 1);
  localparam logic [1:0] LAST_GAP = 2'(GAP_TICKS - 1);

  state_e      state_q, state_d;
  logic [1:0]  quarter_q, quarter_d;
  logic [3:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic        hold_q, hold_d;
  logic        phase_b_q, phase_b_d;
  logic        is_read_q, is_read_d;
  logic [14:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  sdata_q, sdata_d;

  logic        tick;
  logic        tick_en;
  logic        accept;
  logic [1:0]  resp_c;
  logic [7:0]  cur_byte;
  logic        last_bit;
  logic        rx_bit;
  logic [1:0]  last_byte;

  assign tick_en = (state_q == ST_START) || (state_q == ST_BITS) ||
                   (state_q == ST_STOP)  || (state_q == ST_GAP);

  sccb_tick_gen u_tick_gen (
    .config_clk   (config_clk),
    .config_reset (config_reset),
    .enable       (tick_en),
    .sccb_div     (sccb_div),
    .tick         (tick)
  );

  // Phase B byte 1 is the read byte; its transmit value is never driven.
  always_comb begin
    if (phase_b_q) begin
      cur_byte = (byte_q == 2'd0) ? addr_byte(addr_q[14:8], 1'b1) : 8'hFF;
    end else begin
      case (byte_q)
        2'd0:    cur_byte = addr_byte(addr_q[14:8], 1'b0);
        2'd1:    cur_byte = addr_q[7:0];
        default: cur_byte = data_q;
      endcase
    end
  end

  assign last_bit  = (bit_q == 4'd8);
  assign rx_bit    = phase_b_q && (byte_q == 2'd1) && !last_bit;
  assign last_byte = is_read_q ? 2'd1 : 2'd2;

  always_comb begin
    state_d   = state_q;
    quarter_d = quarter_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    hold_d    = hold_q;
    phase_b_d = phase_b_q;
    is_read_d = is_read_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rx_d      = rx_q;
    sdata_d   = sdata_q;
    accept    = 1'b0;
    resp_c    = SRESP_NULL;
    sio_c     = 1'b1;
    sio_d_out = 1'b1;
    sio_d_oe  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mcmd != MCMD_IDLE) begin
          accept    = 1'b1;
          addr_d    = maddr;
          data_d    = mdata;
          is_read_d = (mcmd == MCMD_RD);
          phase_b_d = 1'b0;
          quarter_d = 2'd0;
          bit_d     = 4'd0;
          byte_d    = 2'd0;
          if (mcmd == MCMD_WR || mcmd == MCMD_RD) begin
            state_d = ST_START;
          end else begin
            state_d = ST_ERR;
            sdata_d = 8'h00;
          end
        end
      end

      ST_ERR: begin
        resp_c  = SRESP_ERR;
        hold_d  = 1'b0;
        state_d = ST_HOLD;
      end

      ST_START: begin
        sio_d_oe  = 1'b1;
        sio_d_out = !quarter_q[1];
        if (tick) begin
          quarter_d = quarter_q + 2'd1;
          if (quarter_q == LAST_Q) begin
            state_d = ST_BITS;
            bit_d   = 4'd0;
            byte_d  = 2'd0;
          end
        end
      end

      ST_BITS: begin
        sio_c = quarter_q[1];
        if (last_bit) begin
          // 9th bit is released, except the NA bit closing the read byte
          sio_d_oe = phase_b_q && (byte_q == 2'd1);
        end else if (!rx_bit) begin
          sio_d_oe  = 1'b1;
          sio_d_out = cur_byte[~bit_q[2:0]];
        end
        if (tick) begin
          quarter_d = quarter_q + 2'd1;
          if (rx_bit && quarter_q == 2'd2) begin
            rx_d = {rx_q[6:0], sio_d_in};
          end
          if (quarter_q == LAST_Q) begin
            if (last_bit) begin
              bit_d = 4'd0;
              if (byte_q == last_byte) begin
                state_d = ST_STOP;
              end else begin
                byte_d = byte_q + 2'd1;
              end
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end
      end

      ST_STOP: begin
        sio_d_oe  = 1'b1;
        sio_c     = (quarter_q != 2'd0);
        sio_d_out = (quarter_q == LAST_Q);
        if (tick) begin
          quarter_d = quarter_q + 2'd1;
          if (quarter_q == LAST_Q) begin
            if (is_read_q && !phase_b_q) begin
              state_d = ST_GAP;
            end else begin
              state_d = ST_RESP;
              sdata_d = is_read_q ? rx_q : 8'h00;
            end
          end
        end
      end

      ST_GAP: begin
        if (tick) begin
          quarter_d = quarter_q + 2'd1;
          if (quarter_q == LAST_GAP) begin
            state_d   = ST_START;
            phase_b_d = 1'b1;
          end
        end
      end

      ST_RESP: begin
        resp_c  = SRESP_DVA;
        hold_d  = 1'b0;
        state_d = ST_HOLD;
      end

      ST_HOLD: begin
        // The sequencer's stale command is still on mcmd here; ignore it.
        hold_d = 1'b1;
        if (hold_q) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge config_clk) begin
    if (config_reset) begin
      state_q   <= ST_IDLE;
      quarter_q <= 2'd0;
      bit_q     <= 4'd0;
      byte_q    <= 2'd0;
      hold_q    <= 1'b0;
      phase_b_q <= 1'b0;
      is_read_q <= 1'b0;
      addr_q    <= 15'd0;
      data_q    <= 8'd0;
      rx_q      <= 8'd0;
      sdata_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      quarter_q <= quarter_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      hold_q    <= hold_d;
      phase_b_q <= phase_b_d;
      is_read_q <= is_read_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rx_q      <= rx_d;
      sdata_q   <= sdata_d;
    end
  end

  assign scmdaccept = accept && !config_reset;
  assign sresp      = config_reset ? SRESP_NULL : resp_c;
  assign sdata      = sdata_q;

endmodule
